// File: rtl/iso_pkg.sv
// Shared definitions for the isochronous lane output stage: framing
// K-symbols, source-select encoding and the SR-insertion FSM states.
package iso_pkg;

  localparam logic [7:0] K_BS = 8'hBC;
  localparam logic [7:0] K_SR = 8'h1C;
  localparam logic [7:0] K_BF = 8'hF7;

  typedef enum logic [1:0] {
    SEL_IDLE   = 2'b00,
    SEL_ACTIVE = 2'b01,
    SEL_BLANK  = 2'b10,
    SEL_RSVD   = 2'b11
  } stream_idle_sel_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BF1   = 2'b01,
    S_BF2   = 2'b10,
    S_CLOSE = 2'b11
  } sr_state_e;

  // Swap a control BS for SR; anything else passes through unchanged.
  function automatic logic [7:0] sr_sub(input logic [7:0] sym, input logic flag);
    return (flag && (sym == K_BS)) ? K_SR : sym;
  endfunction

endpackage

// File: rtl/iso_sr_insert.sv
// Scrambler-reset insertion stage: counts opening BS symbols on lane 0 and
// replaces every SR_PERIOD-th BS (and, in enhanced framing, the matching
// closing BS of the BS BF BF BS sequence) with SR on all lanes carrying BS.
// Optional build macro: ISO_SEQ_CHECK_EN adds the seq_mis_o pulse.
module iso_sr_insert
  import iso_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int SR_PERIOD = 512
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [8*LANES-1:0] sym_i,
  input  logic [LANES-1:0]   flg_i,
  input  logic               enh_i,
  output logic [8*LANES-1:0] sym_o,
  output logic [LANES-1:0]   flg_o,
  output logic               sr_o
`ifdef ISO_SEQ_CHECK_EN
  ,
  output logic               seq_mis_o
`endif
);

  localparam int              CNT_W    = $clog2(SR_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SR_PERIOD - 1);

  sr_state_e          state_q, state_d;
  logic [CNT_W-1:0]   bs_cnt_q, bs_cnt_d;
  logic               repl_pend_q, repl_pend_d;

  logic               is_bs0, is_bf0, seq_ok;
  logic               open_bs, cnt_wrap, repl;

  logic [8*LANES-1:0] sym_p2_d, sym_p2_q;
  logic [LANES-1:0]   flg_p2_d, flg_p2_q;
  logic               sr_p2_d, sr_p2_q;

  // Framing decisions are taken on lane 0 only.
  assign is_bs0   = flg_i[0] && (sym_i[7:0] == K_BS);
  assign is_bf0   = flg_i[0] && (sym_i[7:0] == K_BF);
  assign seq_ok   = (state_q == S_CLOSE) ? is_bs0 : is_bf0;
  assign cnt_wrap = (bs_cnt_q == CNT_LAST);

`ifdef ISO_SEQ_CHECK_EN
  // Non-idle states are only reachable in enhanced framing.
  assign seq_mis_o = (state_q != S_IDLE) && !seq_ok;
`endif

  // FSM state, opening-BS counter and pending closing replacement.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      bs_cnt_q    <= '0;
      repl_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bs_cnt_q    <= bs_cnt_d;
      repl_pend_q <= repl_pend_d;
    end
  end

  // Next state: sequence tracking, then opening-BS counting (a symbol that
  // breaks a sequence is reconsidered as a fresh opening BS).
  always_comb begin
    state_d     = state_q;
    bs_cnt_d    = bs_cnt_q;
    repl_pend_d = repl_pend_q;
    open_bs     = 1'b0;
    repl        = 1'b0;
    case (state_q)
      S_IDLE: open_bs = is_bs0;
      S_BF1, S_BF2: begin
        if (seq_ok) begin
          state_d = (state_q == S_BF1) ? S_BF2 : S_CLOSE;
        end else begin
          state_d     = S_IDLE;
          repl_pend_d = 1'b0;
          open_bs     = is_bs0;
        end
      end
      S_CLOSE: begin
        state_d     = S_IDLE;
        repl_pend_d = 1'b0;
        if (seq_ok) begin
          repl = repl_pend_q;
        end else begin
          open_bs = is_bs0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (open_bs) begin
      bs_cnt_d = cnt_wrap ? '0 : bs_cnt_q + CNT_W'(1);
      repl     = cnt_wrap;
      if (enh_i) begin
        state_d     = S_BF1;
        repl_pend_d = cnt_wrap;
      end
    end
  end

  // Output data: substitute SR on every BS lane in a replaced cycle.
  always_comb begin
    sym_p2_d = sym_i;
    flg_p2_d = flg_i;
    sr_p2_d  = repl;
    if (repl) begin
      for (int k = 0; k < LANES; k++) begin
        sym_p2_d[8*k +: 8] = sr_sub(sym_i[8*k +: 8], flg_i[k]);
      end
    end
  end

  // ---- stage 2: SR register ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sym_p2_q <= '0;
      flg_p2_q <= '0;
      sr_p2_q  <= 1'b0;
    end else begin
      sym_p2_q <= sym_p2_d;
      flg_p2_q <= flg_p2_d;
      sr_p2_q  <= sr_p2_d;
    end
  end

  assign sym_o = sym_p2_q;
  assign flg_o = flg_p2_q;
  assign sr_o  = sr_p2_q;

endmodule

// File: rtl/iso_lane_sr_mux.sv
// Multi-lane isochronous output stage: registered idle/active/blank source
// select followed by scrambler-reset insertion (iso_sr_insert).
// Legal LANES: 1, 2, 4. SR_PERIOD: power of two, >= 2.
// Optional build macro: ISO_SEQ_CHECK_EN adds the sticky seq_err output.
module iso_lane_sr_mux
  import iso_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int SR_PERIOD = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*LANES-1:0] active_symbols,
  input  logic [LANES-1:0]   active_control_sym_flag,
  input  logic [8*LANES-1:0] blank_symbols,
  input  logic [LANES-1:0]   blank_control_sym_flag,
  input  logic [8*LANES-1:0] idle_symbols,
  input  logic [LANES-1:0]   idle_control_sym_flag,
  input  logic [1:0]         sched_stream_idle_sel,
  input  logic               enh_frame_en,
  output logic [8*LANES-1:0] iso_symbols,
  output logic [LANES-1:0]   iso_control_sym_flag,
  output logic               sr_inserted
`ifdef ISO_SEQ_CHECK_EN
  ,
  output logic               seq_err
`endif
);

  stream_idle_sel_e   sel;
  logic [8*LANES-1:0] sym_p1_d, sym_p1_q;
  logic [LANES-1:0]   flg_p1_d, flg_p1_q;

  assign sel = stream_idle_sel_e'(sched_stream_idle_sel);

  // Source select; the reserved code falls back to the idle pattern.
  always_comb begin
    sym_p1_d = idle_symbols;
    flg_p1_d = idle_control_sym_flag;
    case (sel)
      SEL_ACTIVE: begin
        sym_p1_d = active_symbols;
        flg_p1_d = active_control_sym_flag;
      end
      SEL_BLANK: begin
        sym_p1_d = blank_symbols;
        flg_p1_d = blank_control_sym_flag;
      end
      default: begin
        sym_p1_d = idle_symbols;
        flg_p1_d = idle_control_sym_flag;
      end
    endcase
  end

  // ---- stage 1: mux register (data only, keeps loading through reset) ----
  always_ff @(posedge clk) begin
    sym_p1_q <= sym_p1_d;
    flg_p1_q <= flg_p1_d;
  end

  // ---- stage 2: SR insertion ----
`ifdef ISO_SEQ_CHECK_EN
  logic seq_mis;
`endif

  iso_sr_insert #(
    .LANES     (LANES),
    .SR_PERIOD (SR_PERIOD)
  ) u_ins (
    .clk_i     (clk),
    .rst_i     (rst),
    .sym_i     (sym_p1_q),
    .flg_i     (flg_p1_q),
    .enh_i     (enh_frame_en),
    .sym_o     (iso_symbols),
    .flg_o     (iso_control_sym_flag),
    .sr_o      (sr_inserted)
`ifdef ISO_SEQ_CHECK_EN
    ,
    .seq_mis_o (seq_mis)
`endif
  );

`ifdef ISO_SEQ_CHECK_EN
  logic seq_err_q, seq_err_d;

  assign seq_err_d = seq_err_q | seq_mis | (sel == SEL_RSVD);

  // Sticky sequence/select error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`endif

endmodule

// File: tb/tb_iso_lane_sr_mux.sv
// Directed bench for iso_lane_sr_mux: a 4-lane and a 1-lane instance
// (both SR_PERIOD=4) share stimulus; lane 0 of every vector drives the 1-lane copy.
`timescale 1ns/1ps
module tb_iso_lane_sr_mux;
  import iso_pkg::*;

  localparam logic [31:0] BS4 = 32'hBCBCBCBC;
  localparam logic [31:0] BF4 = 32'hF7F7F7F7;
  localparam logic [31:0] SR4 = 32'h1C1C1C1C;
  localparam logic [31:0] D4  = 32'h12345678;
  localparam logic [31:0] Z4  = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] act, blk, idl;
  logic [3:0]  actf, blkf, idlf;
  logic [1:0]  sel;
  logic        enh;

  logic [31:0] iso4;
  logic [3:0]  flg4;
  logic        sr4;
  logic [7:0]  iso1;
  logic [0:0]  flg1;
  logic        sr1;
`ifdef ISO_SEQ_CHECK_EN
  logic        se4, se1;
`endif

  typedef struct {
    logic [31:0] s;
    logic [3:0]  f;
    logic        sr;
  } exp_t;

  exp_t  q[$];
  int    nchk, nerr;
  int    sr_cnt4, sr_cnt1;
  string sect;

  always #5 clk = ~clk;

  iso_lane_sr_mux #(.LANES(4), .SR_PERIOD(4)) u4 (
    .clk                     (clk),
    .rst                     (rst),
    .active_symbols          (act),
    .active_control_sym_flag (actf),
    .blank_symbols           (blk),
    .blank_control_sym_flag  (blkf),
    .idle_symbols            (idl),
    .idle_control_sym_flag   (idlf),
    .sched_stream_idle_sel   (sel),
    .enh_frame_en            (enh),
    .iso_symbols             (iso4),
    .iso_control_sym_flag    (flg4),
    .sr_inserted             (sr4)
`ifdef ISO_SEQ_CHECK_EN
    ,
    .seq_err                 (se4)
`endif
  );

  iso_lane_sr_mux #(.LANES(1), .SR_PERIOD(4)) u1 (
    .clk                     (clk),
    .rst                     (rst),
    .active_symbols          (act[7:0]),
    .active_control_sym_flag (actf[0:0]),
    .blank_symbols           (blk[7:0]),
    .blank_control_sym_flag  (blkf[0:0]),
    .idle_symbols            (idl[7:0]),
    .idle_control_sym_flag   (idlf[0:0]),
    .sched_stream_idle_sel   (sel),
    .enh_frame_en            (enh),
    .iso_symbols             (iso1),
    .iso_control_sym_flag    (flg1),
    .sr_inserted             (sr1)
`ifdef ISO_SEQ_CHECK_EN
    ,
    .seq_err                 (se1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one symbol cycle and queue its expected output; the output of the
  // vector applied two edges ago is compared after each edge.
  task automatic cyc(input logic [1:0] s, input logic [31:0] a, input logic [3:0] af,
                     input logic [31:0] es, input logic [3:0] ef, input logic esr);
    exp_t e;
    sel  = s;
    act  = a;
    actf = af;
    e.s  = es;
    e.f  = ef;
    e.sr = esr;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (sr4) sr_cnt4++;
    if (sr1) sr_cnt1++;
    if (q.size() == 2) begin
      e = q.pop_front();
      chk({sect, " sym4"}, iso4, e.s);
      chk({sect, " flg4"}, {28'h0, flg4}, {28'h0, e.f});
      chk({sect, " sr4"},  {31'h0, sr4}, {31'h0, e.sr});
      chk({sect, " sym1"}, {24'h0, iso1}, {24'h0, e.s[7:0]});
      chk({sect, " flg1"}, {31'h0, flg1}, {31'h0, e.f[0]});
      chk({sect, " sr1"},  {31'h0, sr1}, {31'h0, e.sr});
    end
  endtask

  // Active-source symbol with the same symbol expected (optionally as SR).
  task automatic sym(input logic [31:0] a, input logic [3:0] af, input logic repl);
    cyc(2'b01, a, af, repl ? SR4 : a, af, repl);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    sel  = 2'b00;
    act  = '0; actf = '0;
    blk  = '0; blkf = '0;
    idl  = '0; idlf = '0;
    #1;
    chk({sect, " rst sym4"}, iso4, 32'h0);
    chk({sect, " rst flg4"}, {28'h0, flg4}, 32'h0);
    chk({sect, " rst sr4"},  {31'h0, sr4}, 32'h0);
    chk({sect, " rst sym1"}, {24'h0, iso1}, 32'h0);
    chk({sect, " rst sr1"},  {31'h0, sr1}, 32'h0);
`ifdef ISO_SEQ_CHECK_EN
    chk({sect, " rst seq_err"}, {31'h0, se4}, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    sr_cnt4 = 0;
    sr_cnt1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    nchk = 0;
    nerr = 0;
    rst  = 1'b0;
    enh  = 1'b0;
    sel  = 2'b00;
    act  = '0; actf = '0;
    blk  = '0; blkf = '0;
    idl  = '0; idlf = '0;
    #2;

    // Source select
    sect = "srcsel";
    do_reset();
    blk = 32'hB1B2B3B4; blkf = 4'b1010;
    idl = 32'hC1C2C3C4; idlf = 4'b1111;
`ifdef ISO_SEQ_CHECK_EN
    chk("srcsel seq_err before", {31'h0, se4}, 32'h0);
`endif
    cyc(2'b01, 32'hA1A2A3A4, 4'b0101, 32'hA1A2A3A4, 4'b0101, 1'b0);
    cyc(2'b10, 32'hA1A2A3A4, 4'b0101, 32'hB1B2B3B4, 4'b1010, 1'b0);
    cyc(2'b00, 32'hA1A2A3A4, 4'b0101, 32'hC1C2C3C4, 4'b1111, 1'b0);
    cyc(2'b11, 32'hA1A2A3A4, 4'b0101, 32'hC1C2C3C4, 4'b1111, 1'b0);
    cyc(2'b01, 32'hA1A2A3A4, 4'b0101, 32'hA1A2A3A4, 4'b0101, 1'b0);
    cyc(2'b01, 32'hA1A2A3A4, 4'b0101, 32'hA1A2A3A4, 4'b0101, 1'b0);
`ifdef ISO_SEQ_CHECK_EN
    chk("srcsel seq_err4", {31'h0, se4}, 32'h1);
    chk("srcsel seq_err1", {31'h0, se1}, 32'h1);
`endif

    // Standard framing: BS every 8 cycles, SR at BS 4 and BS 8
    sect = "std";
    do_reset();
    enh = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      sym(BS4, 4'hF, (n % 4) == 0);
      repeat (7) sym(D4, 4'h0, 1'b0);
    end
    chk("std sr pulses4", sr_cnt4, 2);
    chk("std sr pulses1", sr_cnt1, 2);

    // Enhanced framing: sequence 4 and 8 become SR BF BF SR
    sect = "enh";
    do_reset();
    enh = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      sym(BS4, 4'hF, (n % 4) == 0);
      sym(BF4, 4'hF, 1'b0);
      sym(BF4, 4'hF, 1'b0);
      sym(BS4, 4'hF, (n % 4) == 0);
      sym(D4, 4'h0, 1'b0);
      sym(D4, 4'h0, 1'b0);
    end
    chk("enh sr pulses4", sr_cnt4, 4);
    chk("enh sr pulses1", sr_cnt1, 4);

    // Broken sequences: BS BF 00, then a full one, then BS BF BS where the
    // third symbol re-opens as the 4th BS and is replaced with its closer.
    sect = "broken";
    do_reset();
    enh = 1'b1;
    sym(BS4, 4'hF, 1'b0);
    sym(BF4, 4'hF, 1'b0);
    sym(Z4, 4'h0, 1'b0);
    sym(D4, 4'h0, 1'b0);
    sym(BS4, 4'hF, 1'b0);
    sym(BF4, 4'hF, 1'b0);
    sym(BF4, 4'hF, 1'b0);
    sym(BS4, 4'hF, 1'b0);
    sym(D4, 4'h0, 1'b0);
    sym(BS4, 4'hF, 1'b0);
    sym(BF4, 4'hF, 1'b0);
    sym(BS4, 4'hF, 1'b1);
    sym(BF4, 4'hF, 1'b0);
    sym(BF4, 4'hF, 1'b0);
    sym(BS4, 4'hF, 1'b1);
    sym(D4, 4'h0, 1'b0);
    sym(D4, 4'h0, 1'b0);
    chk("broken sr pulses4", sr_cnt4, 2);
`ifdef ISO_SEQ_CHECK_EN
    chk("broken seq_err4", {31'h0, se4}, 32'h1);
`endif

    // Reset in S_BF2 with bs_cnt=3; counting restarts from 0
    sect = "rstmid";
    do_reset();
    enh = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      sym(BS4, 4'hF, 1'b0);
      sym(BF4, 4'hF, 1'b0);
      sym(BF4, 4'hF, 1'b0);
      sym(BS4, 4'hF, 1'b0);
      sym(D4, 4'h0, 1'b0);
    end
    sym(BS4, 4'hF, 1'b0);
    sym(BF4, 4'hF, 1'b0);
    sym(BF4, 4'hF, 1'b0);
    chk("rstmid pre fsm", 32'(u4.u_ins.state_q), 32'(S_BF2));
    chk("rstmid pre cnt", 32'(u4.u_ins.bs_cnt_q), 32'd3);
    rst = 1'b1;
    #1;
    chk("rstmid sym4", iso4, 32'h0);
    chk("rstmid flg4", {28'h0, flg4}, 32'h0);
    chk("rstmid sr4", {31'h0, sr4}, 32'h0);
    chk("rstmid fsm", 32'(u4.u_ins.state_q), 32'(S_IDLE));
    chk("rstmid cnt", 32'(u4.u_ins.bs_cnt_q), 32'd0);
    chk("rstmid pend", {31'h0, u4.u_ins.repl_pend_q}, 32'h0);
    do_reset();
    enh = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      sym(BS4, 4'hF, n == 4);
      repeat (3) sym(D4, 4'h0, 1'b0);
    end
    chk("rstmid sr pulses4", sr_cnt4, 1);
    chk("rstmid sr pulses1", sr_cnt1, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
